team_06_echo_buffer: RTL and testbench

Circular sample-history buffer that sits directly beside `team_06_echo_effect` and feeds it. Every sample the echo stage emits on `save_audio` is written here; when the echo stage asserts `search` with an `offset`, this block returns the sample written `offset` writes earlier on `past_output`. Reads of history that does not yet exist return silence (0), so the echo effect never replays uninitialised memory after reset or flush.

---
 rtl/team_06_pkg.sv | 14 +
 rtl/team_06_sram_1r1w.sv | 24 ++
 rtl/team_06_echo_buffer.sv | 120 ++++++++++++
 tb/tb_team_06_echo_buffer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/team_06_pkg.sv
// team_06 shared types for the echo path.
// Sample width, history pointer width, buffer FSM states.
package team_06_pkg;

  localparam int AUDIO_W     = 8;
  localparam int ECHO_ADDR_W = 13;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } echo_buf_state_t;

endpackage

// File: rtl/team_06_sram_1r1w.sv
// Simple dual-port sample store, one write and one registered read.
// Read returns old contents on a same-edge address collision.
module team_06_sram_1r1w #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // unreset array; read samples the pre-write word
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/team_06_echo_buffer.sv
// Circular history of echo samples with offset lookup.
// Lookups beyond the stored history return silence.
module team_06_echo_buffer
  import team_06_pkg::*;
#(
  parameter int DATA_W = AUDIO_W,
  parameter int ADDR_W = ECHO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] save_audio,
  input  logic              save_valid,
  input  logic              clear,
  input  logic              search,
  input  logic [ADDR_W-1:0] offset,
  output logic [DATA_W-1:0] past_output,
  output logic              past_valid,
  output logic [ADDR_W:0]   fill_level,
  output logic              full
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  echo_buf_state_t state, state_nxt;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic              rd_en;
  logic              flush;
  logic              hit;
  logic              hit_q;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next state: leave IDLE at once, clear detours through FLUSH
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (clear) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // strobes: clear beats any same-cycle write or read
  always_comb begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    unique case (state)
      RUN: begin
        flush = clear;
        wr_en = save_valid & ~clear;
        rd_en = search & ~clear;
      end
      FLUSH:   flush = 1'b1;
      default: ;
    endcase
  end

  // lookup uses the pointer and fill before this cycle's write
  always_comb begin
    rd_addr = wr_ptr - offset;
    hit     = (offset != '0) && ({1'b0, offset} <= fill_level);
  end

  // write pointer and saturating fill counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      fill_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      fill_level <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill_level != FULL_LVL)
        fill_level <= fill_level + 1'b1;
    end
  end

  // response strobe and hit flag, held between reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      past_valid <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      past_valid <= rd_en;
      if (rd_en) hit_q <= hit;
    end
  end

  // misses read back as silence
  always_comb begin
    past_output = hit_q ? rd_data : '0;
    full        = (fill_level == FULL_LVL);
  end

  team_06_sram_1r1w #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata(save_audio),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_team_06_echo_buffer.sv
// Bench for team_06_echo_buffer.
// Reference keeps the written samples in a queue and indexes back.
module tb_team_06_echo_buffer;

  localparam int DEPTH = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  save_audio = '0;
  logic        save_valid = 1'b0;
  logic        clear = 1'b0;
  logic        search = 1'b0;
  logic [12:0] offset = '0;
  logic [7:0]  past_output;
  logic        past_valid;
  logic [13:0] fill_level;
  logic        full;

  int n_chk  = 0;
  int n_pass = 0;

  // model: 0 = waiting after reset, 1 = running, 2 = flush cycle
  int         mode = 0;
  logic [7:0] hist[$];
  int         last_po = 0;

  always #5 clk = ~clk;

  team_06_echo_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .save_audio (save_audio),
    .save_valid (save_valid),
    .clear      (clear),
    .search     (search),
    .offset     (offset),
    .past_output(past_output),
    .past_valid (past_valid),
    .fill_level (fill_level),
    .full       (full)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
  endtask

  function automatic int mread(input int off);
    int n = hist.size();
    if (off >= 1 && off <= n) return int'(hist[n-off]);
    return 0;
  endfunction

  task automatic step(input logic sv, input int d, input logic sr,
                      input int off, input logic clr);
    int epv;
    int epo;
    save_valid = sv;
    save_audio = 8'(d);
    search     = sr;
    offset     = 13'(off);
    clear      = clr;
    epv = (mode == 1 && !clr && sr) ? 1 : 0;
    epo = epv ? mread(off) : last_po;
    if (mode == 1 && clr) begin
      hist.delete();
      mode = 2;
    end else begin
      if (mode == 1 && sv) begin
        hist.push_back(8'(d));
        if (hist.size() > DEPTH) void'(hist.pop_front());
      end
      mode = 1;
    end
    @(posedge clk);
    #1;
    chk("valid", int'(past_valid), epv);
    chk("data", int'(past_output), epo);
    chk("fill", int'(fill_level), hist.size());
    chk("full", int'(full), (hist.size() == DEPTH) ? 1 : 0);
    last_po = epo;
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b0;
    mode = 0;
    hist.delete();
    last_po = 0;
    for (int i = 0; i < cyc; i++) begin
      save_valid = 1'($urandom);
      save_audio = 8'($urandom);
      search     = 1'($urandom);
      offset     = 13'($urandom);
      clear      = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst_valid", int'(past_valid), 0);
      chk("rst_data", int'(past_output), 0);
      chk("rst_fill", int'(fill_level), 0);
      chk("rst_full", int'(full), 0);
    end
    save_valid = 1'b0;
    search = 1'b0;
    clear = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(4);
    // ignored while leaving reset, then a miss
    step(1'b1, 8'h99, 1'b1, 1, 1'b0);
    step(1'b0, 0, 1'b1, 1, 1'b0);
    chk("first_miss", int'(past_output), 0);

    step(1'b1, 8'h11, 1'b0, 0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 0, 1'b0);
    for (int k = 1; k <= 4; k++) step(1'b0, 0, 1'b1, k, 1'b0);
    chk("fill3", int'(fill_level), 3);
    step(1'b0, 0, 1'b1, 0, 1'b0);

    // write and read together
    step(1'b1, 8'h44, 1'b1, 1, 1'b0);
    chk("rbw_old", int'(past_output), 8'h33);
    step(1'b0, 0, 1'b1, 1, 1'b0);
    chk("rbw_new", int'(past_output), 8'h44);

    // wrap past full depth
    do_reset(2);
    step(1'b0, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8200; i++) step(1'b1, i & 255, 1'b0, 0, 1'b0);
    chk("wrap_full", int'(full), 1);
    chk("wrap_fill", int'(fill_level), 8192);
    step(1'b0, 0, 1'b1, 8191, 1'b0);
    chk("wrap_oldest", int'(past_output), 8'h09);
    step(1'b0, 0, 1'b1, 1, 1'b0);
    chk("wrap_newest", int'(past_output), 8'h07);
    step(1'b0, 0, 1'b1, 8192 - 8, 1'b0);

    // clear beats write and read
    do_reset(1);
    step(1'b0, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i + 1), 1'b0, 0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1, 1'b1);
    chk("clr_novalid", int'(past_valid), 0);
    step(1'b1, 8'hBB, 1'b1, 1, 1'b0);
    step(1'b0, 0, 1'b1, 1, 1'b0);
    chk("clr_miss", int'(past_output), 0);
    chk("clr_fill", int'(fill_level), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int n = hist.size();
      int off;
      if ($urandom_range(3) == 0) off = int'($urandom_range(DEPTH - 1));
      else off = int'($urandom_range(n + 2));
      if (off > DEPTH - 1) off = DEPTH - 1;
      step(1'($urandom), int'($urandom_range(255)), 1'($urandom), off,
           $urandom_range(60) == 0);
    end

    // reset lands between search and response
    save_valid = 1'b1;
    save_audio = 8'h5A;
    search     = 1'b1;
    offset     = 13'd1;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_valid_async", int'(past_valid), 0);
    do_reset(3);
    step(1'b0, 0, 1'b0, 0, 1'b0);
    chk("mid_fill", int'(fill_level), 0);
    chk("mid_valid", int'(past_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
